factor_sequencer: RTL
=====================

// Module: factor_sequencer
//
// PURPOSE
//   Control sequencer for the factorizer datapath. Latches an 8-bit operand
//   and finds its prime factors by trial division with a repeated-subtraction
//   divider. Presents each factor to the display path for a programmable dwell
//   time, then advances to the next factor.
//
// PARAMETERS
//   MAX_COUNT  10_000_000  dwell per factor in clk cycles (>=2); benches use 4
//   DWELL_W    $clog2(MAX_COUNT)  dwell counter width (derived, do not override)
//
// PORTS
//   clk           in   1  clock, all state on rising edge
//   rst           in   1  asynchronous, active-high reset
//   start         in   1  begin factorizing number; sampled in IDLE/DONE only
//   number        in   8  operand, latched on accepted start
//   hold          in   1  freeze dwell counter while high (display pause)
//   factor        out  8  current prime factor; holds last value outside EMIT
//   factor_valid  out  1  high throughout EMIT
//   factor_strobe out  1  one-cycle pulse on first cycle of each EMIT
//   factor_count  out  3  number of factors emitted since start (max 7: 128=2^7)
//   busy          out  1  high in CHECK, DIVIDE, EMIT
//   done          out  1  high in DONE until next accepted start
//   is_trivial    out  1  in DONE: operand was 0 or 1 (no factors)
//
// BEHAVIOUR
//   Reset: state=IDLE; factor=0, factor_count=0, all flags 0; internal n,d,rem,q=0.
//   Regs: n[7:0] remaining value, d[4:0] divisor (max 16), rem[7:0], q[7:0],
//     dwell[DWELL_W-1:0], last flag. d*d computed combinationally (10 bits).
//   IDLE/DONE: on start=1: n<=number, d<=2, factor_count<=0, done<=0,
//     is_trivial<=0 -> CHECK. start in CHECK/DIVIDE/EMIT is ignored.
//   CHECK (1 cycle): n<2 -> DONE with is_trivial=1 (only reachable at entry);
//     else d*d>n -> factor<=n, last<=1 -> EMIT;
//     else rem<=n, q<=0 -> DIVIDE.
//   DIVIDE (floor(n/d)+1 cycles): rem>=d -> rem<=rem-d, q<=q+1, stay;
//     else rem==0 -> factor<=d, n<=q, last<=0 -> EMIT;
//     else d<=d+1 -> CHECK.
//   EMIT: entry sets dwell<=0, factor_count+=1, factor_strobe=1 for that cycle.
//     Each cycle with hold=0 dwell increments; hold=1 freezes dwell.
//     dwell==MAX_COUNT-1 and hold=0 -> last ? DONE : CHECK (d unchanged, so
//     repeated factors re-test same d). factor_valid=1 for exactly MAX_COUNT
//     non-held cycles.
//   Factors emitted in non-decreasing order; last factor emitted via CHECK path.
//   n never reaches 1 through DIVIDE (q>=d>=2), so no extra end test needed.
//   Reset mid-operation: immediate return to reset values; no partial output.
//   Simultaneous start and hold in IDLE: start wins; hold only affects EMIT.
//
// TESTING (MAX_COUNT=4)
//   number=12, start pulse -> strobes with factor 2,2,3; each factor_valid 4
//     cycles; done=1, factor_count=3, is_trivial=0.
//   number=13 -> single factor 13 (d tries 2,3, stops at d=4), count=1, done=1.
//   number=128 -> seven factors all 2, factor_count=7; number=0 and number=1 ->
//     no strobe, done=1, is_trivial=1, count=0, within 2 cycles of start.
//   number=6, hold high 5 cycles during first EMIT -> factor 2 valid 9 cycles,
//     then factor 3; start pulse with 255 mid-run ignored (still 2,3).
//   Assert rst during DIVIDE of number=221 -> all outputs 0 same cycle, IDLE;
//     restart with 221 -> factors 13,17, count=2.
//   Exhaustive 2..255 vs reference model: product of factors == number, each
//     prime, non-decreasing, count matches, busy low only in IDLE/DONE.

Source files
------------

// File: rtl/factor_sequencer.sv
// Factorizer control sequencer.
// Latches an 8-bit operand and finds its prime factors by trial division,
// using a repeated-subtraction divider. Each factor is held on the display
// outputs for MAX_COUNT non-held cycles before the search continues.
module factor_sequencer #(
    parameter int MAX_COUNT = 10_000_000,
    parameter int DWELL_W   = $clog2(MAX_COUNT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] number,
    input  logic       hold,
    output logic [7:0] factor,
    output logic       factor_valid,
    output logic       factor_strobe,
    output logic [2:0] factor_count,
    output logic       busy,
    output logic       done,
    output logic       is_trivial
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(MAX_COUNT - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ZERO = DWELL_W'(0);

    // Architectural state
    state_t             state_r;
    logic [7:0]         n_r;
    logic [4:0]         d_r;
    logic [7:0]         rem_r;
    logic [7:0]         q_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               last_r;
    logic [7:0]         factor_r;
    logic [2:0]         count_r;
    logic               valid_r;
    logic               strobe_r;
    logic               busy_r;
    logic               done_r;
    logic               trivial_r;

    // Next-state values
    state_t             state_next_s;
    logic [7:0]         n_next_s;
    logic [4:0]         d_next_s;
    logic [7:0]         rem_next_s;
    logic [7:0]         q_next_s;
    logic [DWELL_W-1:0] dwell_next_s;
    logic               last_next_s;
    logic [7:0]         factor_next_s;
    logic [2:0]         count_next_s;
    logic               trivial_next_s;
    logic               valid_next_s;
    logic               strobe_next_s;
    logic               busy_next_s;
    logic               done_next_s;

    // d*d is at most 16*16, so 10 bits never overflow
    logic [9:0]         dd_s;

    assign dd_s = {5'd0, d_r} * {5'd0, d_r};

    // Next-state and datapath decode; every register holds unless a branch updates it
    always_comb begin
        state_next_s   = state_r;
        n_next_s       = n_r;
        d_next_s       = d_r;
        rem_next_s     = rem_r;
        q_next_s       = q_r;
        dwell_next_s   = dwell_r;
        last_next_s    = last_r;
        factor_next_s  = factor_r;
        count_next_s   = count_r;
        trivial_next_s = trivial_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_next_s       = number;
                    d_next_s       = 5'd2;
                    count_next_s   = 3'd0;
                    trivial_next_s = 1'b0;
                    state_next_s   = ST_CHECK;
                end else begin
                    state_next_s   = state_r;
                end
            end
            ST_CHECK: begin
                if (n_r < 8'd2) begin
                    // Only possible straight after start (operand 0 or 1)
                    trivial_next_s = 1'b1;
                    state_next_s   = ST_DONE;
                end else if (dd_s > {2'b00, n_r}) begin
                    // Remaining value is prime: it is the final factor
                    factor_next_s  = n_r;
                    last_next_s    = 1'b1;
                    dwell_next_s   = DWELL_ZERO;
                    count_next_s   = count_r + 3'd1;
                    state_next_s   = ST_EMIT;
                end else begin
                    rem_next_s     = n_r;
                    q_next_s       = 8'd0;
                    state_next_s   = ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                if (rem_r >= {3'b000, d_r}) begin
                    rem_next_s     = rem_r - {3'b000, d_r};
                    q_next_s       = q_r + 8'd1;
                end else if (rem_r == 8'd0) begin
                    factor_next_s  = {3'b000, d_r};
                    n_next_s       = q_r;
                    last_next_s    = 1'b0;
                    dwell_next_s   = DWELL_ZERO;
                    count_next_s   = count_r + 3'd1;
                    state_next_s   = ST_EMIT;
                end else begin
                    d_next_s       = d_r + 5'd1;
                    state_next_s   = ST_CHECK;
                end
            end
            ST_EMIT: begin
                if (hold) begin
                    dwell_next_s   = dwell_r;
                end else if (dwell_r == DWELL_LAST) begin
                    // d is left alone so a repeated factor is re-tested
                    state_next_s   = last_r ? ST_DONE : ST_CHECK;
                end else begin
                    dwell_next_s   = dwell_r + DWELL_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        valid_next_s  = (state_next_s == ST_EMIT);
        strobe_next_s = valid_next_s && (state_r != ST_EMIT);
        busy_next_s   = (state_next_s == ST_CHECK) || (state_next_s == ST_DIVIDE) ||
                        (state_next_s == ST_EMIT);
        done_next_s   = (state_next_s == ST_DONE);
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            n_r       <= 8'd0;
            d_r       <= 5'd0;
            rem_r     <= 8'd0;
            q_r       <= 8'd0;
            dwell_r   <= DWELL_ZERO;
            last_r    <= 1'b0;
            factor_r  <= 8'd0;
            count_r   <= 3'd0;
            valid_r   <= 1'b0;
            strobe_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            trivial_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            n_r       <= n_next_s;
            d_r       <= d_next_s;
            rem_r     <= rem_next_s;
            q_r       <= q_next_s;
            dwell_r   <= dwell_next_s;
            last_r    <= last_next_s;
            factor_r  <= factor_next_s;
            count_r   <= count_next_s;
            valid_r   <= valid_next_s;
            strobe_r  <= strobe_next_s;
            busy_r    <= busy_next_s;
            done_r    <= done_next_s;
            trivial_r <= trivial_next_s;
        end
    end

    assign factor        = factor_r;
    assign factor_valid  = valid_r;
    assign factor_strobe = strobe_r;
    assign factor_count  = count_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign is_trivial    = trivial_r;

endmodule
